// File: rtl/multicycle_cpu_core.sv
// multicycle_cpu_core: multi-cycle RV64/RV32 integer-subset core built around one shared FSM
// (FETCH -> DECODE -> EXEC -> MEM -> WB, plus a terminal HALT state).
//
// Optional feature macro: CPU_PERF_CNT_EN adds the cycle_count and instret_count outputs.
//
// Ports:
//   clk, reset                  clock and asynchronous active-low reset
//   imem_req/addr/ready/rdata   instruction fetch port (word index, req held until ready)
//   dmem_req/we/addr/wdata      data request port (word index, req held until ready)
//   dmem_ready/rdata            data completion; load data valid on the ready cycle
//   retire                      one-cycle pulse per completed instruction
//   halted, illegal             core stopped; illegal is set when the stop was a bad encoding
//   cycle_count, instret_count  free-running counters (CPU_PERF_CNT_EN only)
module multicycle_cpu_core #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted,
    output logic            illegal
`ifdef CPU_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] cycle_count,
    output logic [XLEN-1:0] instret_count
`endif
);

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    localparam logic [PC_W-1:0] PcOne   = PC_W'(1);
    localparam logic [PC_W-1:0] PcReset = PC_W'(RESET_PC);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   regs [32];
    logic              rf_we;
    logic              retire_c;

    // Field decode; IR is stable from DECODE until the next FETCH, so these stay valid.
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       is_r, is_addi, is_ld, is_sd, is_br, is_ecall, is_legal;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    assign is_r     = (opcode == 7'b0110011) &&
                      (((funct3 == 3'b000) && ((funct7 == 7'h00) || (funct7 == 7'h20))) ||
                       (((funct3 == 3'b110) || (funct3 == 3'b111)) && (funct7 == 7'h00)));
    assign is_addi  = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_ld    = (opcode == 7'b0000011) && (funct3 == 3'b011);
    assign is_sd    = (opcode == 7'b0100011) && (funct3 == 3'b011);
    assign is_br    = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
    assign is_ecall = (ir_q == 32'h0000_0073);
    assign is_legal = is_r | is_addi | is_ld | is_sd | is_br | is_ecall;

    logic [XLEN-1:0] imm_i, imm_s;
    assign imm_i = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};

    // B-immediate already shifted right by two: imm[12:2] sign-extended to a word offset.
    logic [PC_W-1:0] br_off, br_target, pc_inc;
    logic            br_taken;
    assign br_off    = {{(PC_W-11){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:9]};
    assign br_target = pc_q + br_off;
    assign pc_inc    = pc_q + PcOne;
    assign br_taken  = (a_q == b_q) ^ funct3[0];

    logic [XLEN-1:0] alu_b, alu_res;
    always_comb begin
        alu_b   = is_r ? b_q : imm_q;
        alu_res = a_q + alu_b;
        if (is_r) begin
            case (funct3)
                3'b111:  alu_res = a_q & b_q;
                3'b110:  alu_res = a_q | b_q;
                default: alu_res = funct7[5] ? (a_q - b_q) : (a_q + b_q);
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        res_d     = res_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;
        retire_c  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d   = (rs1 == 5'd0) ? '0 : regs[rs1];
                b_d   = (rs2 == 5'd0) ? '0 : regs[rs2];
                imm_d = is_sd ? imm_s : imm_i;
                if (!is_legal) begin
                    illegal_d = 1'b1;
                    state_d   = StHalt;
                end else if (is_ecall) begin
                    state_d = StHalt;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_br) begin
                    pc_d     = br_taken ? br_target : pc_inc;
                    retire_c = 1'b1;
                    state_d  = StFetch;
                end else begin
                    res_d   = alu_res;
                    state_d = (is_ld || is_sd) ? StMem : StWb;
                end
            end
            StMem: begin
                if (dmem_ready) begin
                    if (is_sd) begin
                        pc_d     = pc_inc;
                        retire_c = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        res_d   = dmem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we    = (rd != 5'd0);
                pc_d     = pc_inc;
                retire_c = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            pc_q      <= PcReset;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            res_q     <= res_d;
            illegal_q <= illegal_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we) begin
            regs[rd] <= res_q;
        end
    end

    // state_q sits in FETCH during reset, so the fetch request is masked by reset itself.
    assign imem_req   = reset && (state_q == StFetch);
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == StMem);
    assign dmem_we    = (state_q == StMem) && is_sd;
    assign dmem_addr  = res_q;
    assign dmem_wdata = b_q;
    assign retire     = reset && retire_c;
    assign halted     = (state_q == StHalt);
    assign illegal    = illegal_q;

`ifdef CPU_PERF_CNT_EN
    logic [XLEN-1:0] cycle_q, instret_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + XLEN'(1);
            if (retire) instret_q <= instret_q + XLEN'(1);
        end
    end
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// tb_multicycle_cpu_core: directed self-checking bench for multicycle_cpu_core with
// behavioural instruction memory (zero wait) and data memory (programmable wait states).
module tb_multicycle_cpu_core;
    localparam int XLEN = 64;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            imem_req, imem_ready;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            dmem_req, dmem_we, dmem_ready;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic            retire, halted, illegal;
`ifdef CPU_PERF_CNT_EN
    logic [XLEN-1:0] cycle_count, instret_count;
`endif

    always #5 clk = ~clk;

    multicycle_cpu_core #(.XLEN(XLEN), .RESET_PC(0), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .retire(retire), .halted(halted), .illegal(illegal)
`ifdef CPU_PERF_CNT_EN
        , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
    );

    logic [31:0]     imem [64];
    logic [XLEN-1:0] dmem [64];
    int dwait = 0;
    int dcnt;
    int cyc;

    assign imem_ready = imem_req;
    assign imem_rdata = imem[imem_addr[5:0]];
    assign dmem_ready = dmem_req && (dcnt == dwait);
    assign dmem_rdata = dmem[dmem_addr[5:0]];

    always @(posedge clk or negedge reset) begin
        if (!reset) dcnt <= 0;
        else if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
        else dcnt <= 0;
    end

    // Cycle 1 is the cycle immediately after reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 1;
        else cyc <= cyc + 1;
    end

    int ret_q[$];
    int fetch_q[$];
    int wr_cnt, we_held;
    logic [XLEN-1:0] wr_addr, wr_data;

    always @(negedge clk) begin
        if (!reset) begin
            ret_q.delete();
            fetch_q.delete();
            wr_cnt  <= 0;
            we_held <= 0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
        end else begin
            if (retire) ret_q.push_back(cyc);
            if (imem_req && imem_ready) fetch_q.push_back(int'(imem_addr));
            if (dmem_req && dmem_we) we_held <= we_held + 1;
            if (dmem_req && dmem_ready && dmem_we) begin
                dmem[dmem_addr[5:0]] <= dmem_wdata;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= dmem_addr;
                wr_data <= dmem_wdata;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input int imm);
        logic [11:0] i12 = imm[11:0];
        return {i12, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_sd(input logic [4:0] rs2, input logic [4:0] rs1,
                                           input int imm);
        logic [11:0] i12 = imm[11:0];
        return {i12[11:5], rs2, rs1, 3'b011, i12[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input int imm);
        logic [12:0] b = imm[12:0];
        return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'h63};
    endfunction

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = ECALL;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_halt(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_imem_req got %0b want 0", imem_req); end
        tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL rst_dmem_req got %0b want 0", dmem_req); end
        tests++; if (retire !== 1'b0 || halted !== 1'b0 || illegal !== 1'b0) begin
            fails++; $display("FAIL rst_status got r%0b h%0b i%0b want 000", retire, halted, illegal);
        end
        tests++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL rst_pc got %0d want 0", imem_addr); end
        tests++; if (dut.regs[7] !== 64'd0) begin fails++; $display("FAIL rst_reg got %0h want 0", dut.regs[7]); end
    endtask

    task automatic test_alu();
        bit ok;
        clear_imem();
        imem[0] = enc_i(7'h13, 3'b000, 5'd1, 5'd0, 5);
        imem[1] = enc_i(7'h13, 3'b000, 5'd2, 5'd0, 7);
        imem[2] = enc_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd2);
        imem[3] = ECALL;
        dwait = 0;
        apply_reset();
        @(negedge clk);
        tests++; if (imem_req !== 1'b1 || cyc !== 1) begin
            fails++; $display("FAIL first_fetch got req=%0b cyc=%0d want req=1 cyc=1", imem_req, cyc);
        end
        wait_halt(60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL alu_halt_timeout got halted=0 want 1"); end
        tests++; if (dut.regs[3] !== 64'd12) begin fails++; $display("FAIL alu_x3 got %0d want 12", dut.regs[3]); end
        tests++; if (ret_q.size() !== 3 || q_at(ret_q, 0) !== 4 || q_at(ret_q, 1) !== 8 ||
                     q_at(ret_q, 2) !== 12) begin
            fails++; $display("FAIL alu_retire got n=%0d %0d,%0d,%0d want n=3 4,8,12", ret_q.size(),
                              q_at(ret_q, 0), q_at(ret_q, 1), q_at(ret_q, 2));
        end
        tests++; if (illegal !== 1'b0 || imem_req !== 1'b0) begin
            fails++; $display("FAIL alu_halt_state got illegal=%0b req=%0b want 0 0", illegal, imem_req);
        end
    endtask

    task automatic test_mem();
        bit ok;
        clear_imem();
        imem[0] = enc_i(7'h13, 3'b000, 5'd3, 5'd0, 12);
        imem[1] = enc_sd(5'd3, 5'd0, 10);
        imem[2] = enc_i(7'h03, 3'b011, 5'd4, 5'd0, 10);
        imem[3] = ECALL;
        dwait = 3;
        apply_reset();
        wait_halt(80, ok);
        tests++; if (!ok) begin fails++; $display("FAIL mem_halt_timeout got halted=0 want 1"); end
        tests++; if (wr_cnt !== 1 || wr_addr !== 64'd10 || wr_data !== 64'd12) begin
            fails++; $display("FAIL mem_store got n=%0d addr=%0d data=%0d want n=1 addr=10 data=12",
                              wr_cnt, wr_addr, wr_data);
        end
        tests++; if (we_held !== 4) begin fails++; $display("FAIL mem_req_held got %0d want 4", we_held); end
        tests++; if (dut.regs[4] !== 64'd12) begin fails++; $display("FAIL mem_x4 got %0d want 12", dut.regs[4]); end
        tests++; if (ret_q.size() !== 3 || q_at(ret_q, 0) !== 4 || q_at(ret_q, 1) !== 11 ||
                     q_at(ret_q, 2) !== 19) begin
            fails++; $display("FAIL mem_retire got n=%0d %0d,%0d,%0d want n=3 4,11,19", ret_q.size(),
                              q_at(ret_q, 0), q_at(ret_q, 1), q_at(ret_q, 2));
        end
    endtask

    task automatic test_branch();
        bit ok;
        // Taken BEQ from pc 6 back to pc 4 (ECALL there).
        clear_imem();
        imem[0] = enc_i(7'h13, 3'b000, 5'd1, 5'd0, 1);
        imem[1] = enc_b(3'b000, 5'd0, 5'd0, 20);
        imem[6] = enc_b(3'b000, 5'd1, 5'd1, -8);
        dwait = 0;
        apply_reset();
        wait_halt(60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL beq_halt_timeout got halted=0 want 1"); end
        tests++; if (fetch_q.size() !== 4 || q_at(fetch_q, 2) !== 6 || q_at(fetch_q, 3) !== 4) begin
            fails++; $display("FAIL beq_fetch got n=%0d %0d,%0d,%0d,%0d want n=4 0,1,6,4", fetch_q.size(),
                              q_at(fetch_q, 0), q_at(fetch_q, 1), q_at(fetch_q, 2), q_at(fetch_q, 3));
        end
        tests++; if (q_at(ret_q, 1) !== 7 || q_at(ret_q, 2) !== 10) begin
            fails++; $display("FAIL beq_retire got %0d,%0d want 7,10", q_at(ret_q, 1), q_at(ret_q, 2));
        end
        // Not-taken BNE at pc 6 falls through to pc 7.
        clear_imem();
        imem[0] = enc_i(7'h13, 3'b000, 5'd1, 5'd0, 1);
        imem[1] = enc_b(3'b000, 5'd0, 5'd0, 20);
        imem[6] = enc_b(3'b001, 5'd1, 5'd1, -8);
        imem[4] = NOP;
        apply_reset();
        wait_halt(60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bne_halt_timeout got halted=0 want 1"); end
        tests++; if (fetch_q.size() !== 4 || q_at(fetch_q, 3) !== 7) begin
            fails++; $display("FAIL bne_fetch got n=%0d last=%0d want n=4 last=7", fetch_q.size(),
                              q_at(fetch_q, 3));
        end
    endtask

    task automatic test_x0_wrap();
        bit ok;
        clear_imem();
        imem[0] = enc_i(7'h13, 3'b000, 5'd0, 5'd0, 9);
        imem[1] = enc_i(7'h13, 3'b000, 5'd1, 5'd0, 1);
        imem[2] = enc_r(7'h20, 3'b000, 5'd5, 5'd0, 5'd1);
        imem[3] = enc_r(7'h00, 3'b110, 5'd6, 5'd0, 5'd1);
        imem[4] = enc_r(7'h00, 3'b111, 5'd7, 5'd5, 5'd1);
        dwait = 0;
        apply_reset();
        wait_halt(80, ok);
        tests++; if (!ok) begin fails++; $display("FAIL x0_halt_timeout got halted=0 want 1"); end
        tests++; if (dut.regs[0] !== 64'd0) begin fails++; $display("FAIL x0_write got %0d want 0", dut.regs[0]); end
        tests++; if (dut.regs[5] !== {XLEN{1'b1}}) begin
            fails++; $display("FAIL sub_wrap got %0h want ffffffffffffffff", dut.regs[5]);
        end
        tests++; if (dut.regs[6] !== 64'd1 || dut.regs[7] !== 64'd1) begin
            fails++; $display("FAIL or_and got %0d,%0d want 1,1", dut.regs[6], dut.regs[7]);
        end
    endtask

    task automatic test_illegal();
        bit ok;
        clear_imem();
        imem[0] = 32'hFFFF_FFFF;
        dwait = 0;
        apply_reset();
        wait_halt(20, ok);
        tests++; if (!ok) begin fails++; $display("FAIL ill_halt_timeout got halted=0 want 1"); end
        repeat (8) @(negedge clk);
        tests++; if (halted !== 1'b1 || illegal !== 1'b1) begin
            fails++; $display("FAIL ill_status got h=%0b i=%0b want 1 1", halted, illegal);
        end
        tests++; if (fetch_q.size() !== 1 || ret_q.size() !== 0 || imem_req !== 1'b0) begin
            fails++; $display("FAIL ill_quiet got fetches=%0d retires=%0d req=%0b want 1 0 0",
                              fetch_q.size(), ret_q.size(), imem_req);
        end
    endtask

    task automatic test_reset_mid_mem();
        bit ok;
        int n;
        clear_imem();
        imem[0] = enc_i(7'h13, 3'b000, 5'd3, 5'd0, 12);
        imem[1] = enc_sd(5'd3, 5'd0, 5);
        dwait = 5;
        apply_reset();
        n = 0;
        while (!dmem_req && n < 20) begin @(negedge clk); n++; end
        tests++; if (!dmem_req) begin fails++; $display("FAIL rmm_no_dmem_req got 0 want 1"); end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        tests++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin
            fails++; $display("FAIL rmm_req_drop got d=%0b i=%0b want 0 0", dmem_req, imem_req);
        end
        tests++; if (imem_addr !== 32'd0 || dut.regs[3] !== 64'd0) begin
            fails++; $display("FAIL rmm_state got pc=%0d x3=%0d want 0 0", imem_addr, dut.regs[3]);
        end
`ifdef CPU_PERF_CNT_EN
        tests++; if (cycle_count !== 64'd0 || instret_count !== 64'd0) begin
            fails++; $display("FAIL rmm_counters got %0d,%0d want 0,0", cycle_count, instret_count);
        end
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        tests++; if (imem_req !== 1'b1 || cyc !== 1) begin
            fails++; $display("FAIL rmm_first_fetch got req=%0b cyc=%0d want 1 1", imem_req, cyc);
        end
        wait_halt(60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rmm_halt_timeout got halted=0 want 1"); end
        tests++; if (q_at(ret_q, 0) !== 4 || q_at(ret_q, 1) !== 13 || wr_cnt !== 1 ||
                     wr_data !== 64'd12) begin
            fails++; $display("FAIL rmm_rerun got ret=%0d,%0d writes=%0d data=%0d want 4,13 1 12",
                              q_at(ret_q, 0), q_at(ret_q, 1), wr_cnt, wr_data);
        end
    endtask

    initial begin
        clear_imem();
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_x0_wrap();
        test_illegal();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu_core.md
Name: multicycle_cpu_core

Overview:
Parametrised multi-cycle successor to the single-cycle RV64 datapath.
- Executes a RISC-V integer subset over one shared FSM.
- Fetches instructions and accesses data through external req/ready memory ports, so memories may have wait states.
- Holds its own XLEN-wide register file and PC.
- Reports each retired instruction and stops on ECALL or an illegal opcode.

Parameters:
- XLEN, 64: datapath, register and data-address width (32 or 64 legal).
- RESET_PC, 0: PC value loaded on reset (word index).
- PC_W, 32: PC and instruction-address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req  out  1  instruction fetch request; held until imem_ready.
- imem_addr  out  PC_W  instruction word index (equals pc).
- imem_ready  in  1  fetch done; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- dmem_req  out  1  data access request; held until dmem_ready.
- dmem_we  out  1  1 = store, 0 = load; stable while dmem_req is high.
- dmem_addr  out  XLEN  data word index (ALU result).
- dmem_wdata  out  XLEN  store data (rs2 value).
- dmem_ready  in  1  access done; dmem_rdata valid in the same cycle for loads.
- dmem_rdata  in  XLEN  load data.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  core stopped (ECALL or illegal instruction).
- illegal  out  1  sticky; set when the halt was caused by an unsupported encoding.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, state=FETCH, IR=0, all registers 0.
  - All outputs 0, except imem_req, which asserts in the first cycle after release.
  - Reset asserted mid-transaction drops imem_req/dmem_req immediately; no register or PC write occurs.
- Supported instructions:
  - R-type ADD/SUB/AND/OR (opcode 0110011; SUB when funct7[5]=1).
  - ADDI (0010011, funct3 000).
  - LD (0000011, funct3 011) and SD (0100011, funct3 011).
  - BEQ/BNE (1100011, funct3 000/001).
  - ECALL (0x00000073).
  - Anything else is illegal.
- Immediates: I/S/B forms, sign-extended to XLEN.
- Addressing: instruction and data addresses are word indices.
  - pc_next = pc+1.
  - Branch target = pc + (B-imm >>> 2), truncated to PC_W.
  - Load/store address = rs1 + imm (mod 2^XLEN).
- Arithmetic: all ALU results are XLEN-bit, wrap on overflow, and set no flags.
- FSM states are FETCH, DECODE, EXEC, MEM, WB, HALT:
  - FETCH: imem_req=1. On the imem_ready cycle, latch IR and go to DECODE.
  - DECODE: read rs1/rs2 into A/B and form the immediate.
    - Illegal encoding: go to HALT with illegal=1.
    - ECALL: go to HALT.
    - Otherwise: go to EXEC.
  - EXEC, R/ADDI: latch ALU result and go to WB.
  - EXEC, LD/SD: latch address and go to MEM.
  - EXEC, BEQ/BNE: pc = taken ? target : pc+1, pulse retire, go to FETCH.
  - MEM: dmem_req=1, dmem_we=(SD).
    - On dmem_ready, LD latches data and goes to WB.
    - On dmem_ready, SD sets pc+1, pulses retire and goes to FETCH.
  - WB: write rd (writes to x0 discarded), pc+1, pulse retire, go to FETCH.
  - HALT: terminal; halted=1, no requests. Left only by reset.
- Latency with zero-wait memory:
  - Branch: 3 cycles.
  - R/ADDI: 4 cycles.
  - SD: 4 cycles.
  - LD: 5 cycles.
  - Each wait cycle adds 1.
- Request stability: imem_addr, dmem_addr, dmem_we and dmem_wdata are constant while the corresponding req is high. Req drops the cycle after ready.
- x0 reads always return 0. rs==rd within one instruction reads the old value.
- PC wrap: pc increments modulo 2^PC_W, with no trap.

Optional Feature:
CPU_PERF_CNT_EN
- When defined, adds two XLEN-wide outputs:
  - cycle_count: increments every non-reset cycle, including HALT.
  - instret_count: increments on each retire.
  - Both wrap and both reset to 0.
- When undefined, these ports and their counters do not exist. Core behaviour is identical either way.

Test Plan:
- Test 1, zero-wait memory: ADDI x1,x0,5 then ADDI x2,x0,7 then ADD x3,x1,x2 then ECALL.
  - Expect x3=12.
  - Expect retire pulses at cycles 4, 8 and 12 after release.
  - Expect halted=1 and illegal=0.
- Test 2, stores and loads:
  - Stimulus: SD x3,10(x0) with dmem_ready delayed 3 cycles, then LD x4,10(x0).
  - dmem sees a write to address 10 with data 12, req held 4 cycles.
  - Expect x4=12.
  - Expect SD retire 3 cycles later than with zero wait.
- Test 3, branches:
  - BEQ x1,x1 with B-imm=-8 at pc=6: next fetch at pc=4.
  - BNE x1,x1 at pc=6: next fetch at pc=7.
- Test 4, x0 and wrap:
  - ADDI x0,x0,9 leaves x0=0.
  - SUB x5,x0,x1 with x1=1 gives x5=2^XLEN-1.
- Test 5, illegal encoding: fetch 0xFFFFFFFF.
  - Expect halted=1 and illegal=1.
  - Expect no further imem_req and no retire.
- Test 6, reset mid-MEM: drive reset=0 while dmem_req=1.
  - Expect dmem_req=0 immediately and pc=RESET_PC.
  - Expect the first imem_req one cycle after release.
  - With CPU_PERF_CNT_EN, both counters read 0.
